// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word producer / link side, slave = the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, sout, sout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out serializer with valid/ready load and bit-rate enable.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             sout_valid_reg, sout_valid_next;
  logic             load_ready_reg, load_ready_next;
  logic             frame_start_reg, frame_start_next;
  logic             frame_end_reg, frame_end_next;

`ifdef PISO_PARITY_EN
  logic             parity_reg, parity_next;
  logic [WIDTH:0]   par_chain;

  assign par_chain[0] = 1'b0;
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_par
    assign par_chain[gi+1] = par_chain[gi] ^ bus.load_data[gi];
  end
`endif

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
`ifdef PISO_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.load_valid) begin
          shreg_next = bus.load_data;
          cnt_next   = '0;
          state_next = SHIFT;
`ifdef PISO_PARITY_EN
          parity_next = par_chain[WIDTH];
`endif
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
`ifdef PISO_PARITY_EN
            state_next = PARITY;
`else
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (bus.shift_en) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from next-state values and then registered,
    // so nothing on the bus depends combinationally on inputs.
    load_ready_next  = (state_next == IDLE);
    sout_valid_next  = (state_next != IDLE);
    frame_start_next = (state_next == SHIFT) && (cnt_next == '0);
`ifdef PISO_PARITY_EN
    sout_next      = ((state_next == SHIFT) && shreg_next[WIDTH-1]) ||
                     ((state_next == PARITY) && parity_next);
    frame_end_next = (state_next == PARITY);
`else
    sout_next      = (state_next == SHIFT) && shreg_next[WIDTH-1];
    frame_end_next = (state_next == SHIFT) && (cnt_next == LAST);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      cnt_reg         <= '0;
      sout_reg        <= 1'b0;
      sout_valid_reg  <= 1'b0;
      load_ready_reg  <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      cnt_reg         <= cnt_next;
      sout_reg        <= sout_next;
      sout_valid_reg  <= sout_valid_next;
      load_ready_reg  <= load_ready_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
`ifdef PISO_PARITY_EN
      parity_reg      <= parity_next;
`endif
    end
  end

  assign bus.load_ready  = load_ready_reg;
  assign bus.busy        = ~load_ready_reg;
  assign bus.sout        = sout_reg;
  assign bus.sout_valid  = sout_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_end   = frame_end_reg;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: frame-level reference model,
// table-driven frames, hand sequences for corner cases, and random traffic.
module tb_piso_serializer;
  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();
  piso_serializer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a frame is just a list of bits and a position in it.
  bit m_active = 1'b0;
  bit m_bits[$];
  int m_pos = 0;

  bit             rx[$];
  logic [WIDTH-1:0] sipo = '0;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               stall_pos;
    int               stall_len;
    logic [FLEN-1:0]  exp_stream;
    int               exp_cycles;
  } vec_t;
  vec_t vecs[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_bits.delete();
    m_pos = 0;
  endfunction

  function automatic void model_edge(bit lv, logic [WIDTH-1:0] ld, bit se);
    if (!m_active) begin
      if (lv) begin
        m_bits.delete();
        for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(ld[i]);
`ifdef PISO_PARITY_EN
        m_bits.push_back(($countones(ld) % 2) == 1);
`endif
        m_pos    = 0;
        m_active = 1'b1;
      end
    end else if (se) begin
      m_pos++;
      if (m_pos == m_bits.size()) m_active = 1'b0;
    end
  endfunction

  function automatic void check_all();
    chk("load_ready",  bus.load_ready,  m_active ? 0 : 1);
    chk("busy",        bus.busy,        m_active ? 1 : 0);
    chk("sout_valid",  bus.sout_valid,  m_active ? 1 : 0);
    chk("sout",        bus.sout,        m_active ? m_bits[m_pos] : 0);
    chk("frame_start", bus.frame_start, (m_active && m_pos == 0) ? 1 : 0);
    chk("frame_end",   bus.frame_end,   (m_active && m_pos == m_bits.size() - 1) ? 1 : 0);
  endfunction

  function automatic logic [31:0] rx_val();
    logic [31:0] v = '0;
    foreach (rx[i]) v = {v[30:0], rx[i]};
    return v;
  endfunction

  // One clock: drive inputs, capture consumed bit (loopback SIPO), advance model, check.
  task automatic cycle(bit lv, logic [WIDTH-1:0] ld, bit se);
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.shift_en   = se;
    if (bus.sout_valid === 1'b1 && se) begin
      rx.push_back(bus.sout);
`ifdef PISO_PARITY_EN
      if (bus.frame_end !== 1'b1) sipo = {sipo[WIDTH-2:0], bus.sout};
`else
      sipo = {sipo[WIDTH-2:0], bus.sout};
`endif
    end
    @(posedge clk);
    cyc++;
    model_edge(lv, ld, se);
    #1;
    check_all();
  endtask

  task automatic run_vec(vec_t v, int idx);
    int pos = 0;
    int stalled = 0;
    int n = 0;
    bit se;
    rx.delete();
    cycle(1'b1, v.word, 1'b1);
    while (bus.sout_valid === 1'b1 && n < 64) begin
      se = !(pos == v.stall_pos && stalled < v.stall_len);
      if (se) pos++;
      else stalled++;
      cycle(1'b0, WIDTH'($urandom), se);
      n++;
    end
    chk("vec_done",   bus.sout_valid, 0);
    chk("vec_stream", rx_val(), 32'(v.exp_stream));
    chk("vec_cycles", n, v.exp_cycles);
    $display("vec %0d: word=%b stream=%h cycles=%0d", idx, v.word, rx_val(), n);
  endtask

  initial begin
`ifdef PISO_PARITY_EN
    vecs[0] = '{4'b1011, -1, 0, 5'b10111, 5};
    vecs[1] = '{4'b0110,  1, 3, 5'b01100, 8};
    vecs[2] = '{4'b0001, -1, 0, 5'b00011, 5};
    vecs[3] = '{4'b0011, -1, 0, 5'b00110, 5};
    vecs[4] = '{4'b1111,  0, 2, 5'b11110, 7};
    vecs[5] = '{4'b1000,  3, 1, 5'b10001, 6};
`else
    vecs[0] = '{4'b1011, -1, 0, 4'b1011, 4};
    vecs[1] = '{4'b0110,  1, 3, 4'b0110, 7};
    vecs[2] = '{4'b0001, -1, 0, 4'b0001, 4};
    vecs[3] = '{4'b0011, -1, 0, 4'b0011, 4};
    vecs[4] = '{4'b1111,  0, 2, 4'b1111, 6};
    vecs[5] = '{4'b1000,  3, 1, 4'b1000, 5};
`endif

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.shift_en   = 1'b0;
    reset          = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;
    check_all();
    $display("reset: load_ready=%b sout_valid=%b", bus.load_ready, bus.load_data[0] & 1'b0 | bus.sout_valid);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Load while busy: 1111 offered throughout the 0001 frame must be ignored.
    rx.delete();
    cycle(1'b1, 4'b0001, 1'b1);
    for (int n = 0; n < 64 && bus.load_ready !== 1'b1; n++) cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
`ifdef PISO_PARITY_EN
    chk("busy_load_stream", rx_val(), 32'b00011);
`else
    chk("busy_load_stream", rx_val(), 32'b0001);
`endif
    $display("load while busy: stream=%h", rx_val());

    // Reset during the second bit aborts the frame immediately.
    cycle(1'b1, 4'b1011, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    chk("pre_reset_valid", bus.sout_valid, 1);
    #1 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    cyc++;
    #1 reset = 1'b0;
    check_all();
    cycle(1'b0, 4'b0000, 1'b1);
    $display("reset mid-frame: load_ready=%b sout_valid=%b", bus.load_ready, bus.sout_valid);

    // Loopback, back-to-back 1011 then 0100 with the minimum one-cycle gap.
    rx.delete();
    sipo = '0;
    cycle(1'b1, 4'b1011, 1'b1);
    for (int n = 0; n < 64 && bus.load_ready !== 1'b1; n++) cycle(1'b1, 4'b0100, 1'b1);
    chk("loopback_first", sipo, 4'b1011);
    cycle(1'b1, 4'b0100, 1'b1);
    chk("gap_accept", bus.busy, 1);
    for (int n = 0; n < 64 && bus.load_ready !== 1'b1; n++) cycle(1'b0, 4'b0000, 1'b1);
    chk("loopback_second", sipo, 4'b0100);
`ifdef PISO_PARITY_EN
    chk("b2b_stream", rx_val(), 32'b10111_01001);
`else
    chk("b2b_stream", rx_val(), 32'b1011_0100);
`endif
    $display("loopback: sipo=%b stream=%h", sipo, rx_val());

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom % 2), WIDTH'($urandom), ($urandom % 4) != 0);
    $display("random: 400 cycles done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer that turns a WIDTH-bit word into an MSB-first bit stream, one bit per qualified clock. It is the transmit-side counterpart of the team's 4-bit serial-in shift register, which shifts new bits in at the LSB. Fed through that register, a frame from this block leaves the word in its original bit order. A valid/ready load handshake and a bit-rate enable let it sit between a word-oriented producer and a serial link or bit-rate generator.

## Interface
- WIDTH, 4, data word width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- load_valid  input  1  producer offers load_data this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- load_ready  output  1  block can accept a word; high only in IDLE.
- shift_en  input  1  bit-rate enable; the presented bit is consumed on an edge where shift_en=1.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a frame bit.
- frame_start  output  1  high while the first bit (word MSB) is presented.
- frame_end  output  1  high while the last bit of the frame is presented.
- busy  output  1  equal to ~load_ready.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only when the macro is defined).
- IDLE
  - load_ready=1, sout_valid=0, sout=0.
  - On load_valid=1, load_data is captured into the shift register and the bit counter is cleared; next state is SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT
  - sout = shift register MSB; sout_valid=1.
  - Edge with shift_en=1: register shifts left by one (zero fill) and the counter increments.
  - Edge with shift_en=0: register and counter hold, and sout stays stable.
  - Leaving SHIFT: when the bit at counter index WIDTH-1 is consumed, next state is IDLE (or PARITY).
- PARITY: sout = even parity of the captured word; sout_valid=1. Consumed on shift_en=1, then next state is IDLE.
- frame_start = sout_valid & (state==SHIFT) & (counter==0).
- frame_end = sout_valid & (last bit of the frame is presented).
- Handshake
  - load_valid while busy is ignored: no capture and no effect on the current frame.
  - load_data needs to be valid only on the accepting edge.
- Counter width is $clog2(WIDTH+1). The counter never exceeds WIDTH-1 in SHIFT, so it has no wrap-around.
- Reset values: load_ready=1, busy=0, sout=0, sout_valid=0, frame_start=0, frame_end=0; state IDLE; shift register and counter zero.
- Reset mid-frame aborts the frame immediately. The remaining bits are lost and no partial frame resumes.

## Timing
- Load latency: load_valid is accepted at edge N; the MSB appears on sout after edge N, in cycle N+1.
- With shift_en held high:
  - a frame occupies exactly WIDTH cycles (WIDTH+1 with parity);
  - load_ready returns high in the cycle after the last bit is consumed.
- Back-to-back frames have a minimum gap of one IDLE cycle: a word can be accepted in that cycle, and its MSB follows one cycle later.
- Each shift_en=0 cycle adds exactly one cycle to the frame. The frame is never shortened.
- All outputs are registered or decoded from registered state only; none depend combinationally on inputs.

## Configuration
- PISO_PARITY_EN
  - Defined: the PARITY state is compiled in. One even-parity bit (XOR of all WIDTH captured bits) follows the LSB, and frame_end marks the parity bit.
  - Undefined: no PARITY state and no parity logic; frame_end marks the LSB, and frames are WIDTH bits long.

## Test plan
- Basic frame: reset, then load 4'b1011 with shift_en=1 continuously.
  - sout reads 1,0,1,1 in cycles N+1..N+4.
  - frame_start is high in N+1; frame_end is high in N+4.
  - load_ready is high again in N+5.
- Stall: load 4'b0110 and drop shift_en for 3 cycles while bit 2 is presented. sout holds 1 through the stall, and the frame ends 3 cycles later.
- Load while busy: assert load_valid with 4'b1111 mid-frame of 4'b0001. The output stream stays 0,0,0,1 and 4'b1111 is never transmitted.
- Reset mid-frame: assert reset during the second bit. All outputs go to their reset values immediately; after release load_ready=1 and sout_valid=0.
- Loopback: feed sout into a 4-bit SIPO clocked with shift_en gating. After the frame of 4'b1011, the SIPO holds 4'b1011. Back-to-back 4'b1011 then 4'b0100 both arrive intact.
- Parity (PISO_PARITY_EN defined): load 4'b1011. sout reads 1,0,1,1,1, with frame_end on the fifth bit. Load 4'b0011: the parity bit is 0.
